// File: rtl/cpu_pkg.sv
// Shared control-core types: ALU control, instruction fields and FSM state encodings.
package cpu_pkg;

  typedef struct packed {
    logic [2:0] reserved;
    logic       carry_in;
  } AluCtrl;

  typedef logic [31:0] Instruction;
  typedef logic [4:0]  RegAddr;

  typedef enum logic [6:0] {
    OpLoad   = 7'b0000011,
    OpImm    = 7'b0010011,
    OpStore  = 7'b0100011,
    OpReg    = 7'b0110011,
    OpBranch = 7'b1100011,
    OpJal    = 7'b1101111
  } OpCode;

  typedef struct packed {
    logic [2:0] nibbles_number;
    logic       word2_is_negative;
    AluCtrl     ctrl;
  } DecodedAluCmd;

  typedef struct packed {
    logic write_rd;
    logic use_imm;
    logic is_branch;
    logic is_mem;
  } WiredDecisions;

  typedef enum logic [1:0] {
    CtrlFetch,
    CtrlDecode,
    CtrlExecute,
    CtrlWriteback
  } ControlState;

  typedef enum logic [1:0] {
    AluIdle,
    AluRun,
    AluDone
  } AluState;

endpackage

// File: rtl/nibble_adder.sv
// Combinational 4-bit adder slice with carry in/out.
module nibble_adder (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] s_o,
  output logic       cout_o
);

  always_comb begin
    {cout_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {4'b0, cin_i};
  end

endmodule

// File: rtl/loop_over_all_nibbles.sv
// Nibble-serial 32-bit adder: one nibble per clock, stops once upper nibbles cannot change.
module loop_over_all_nibbles
  import cpu_pkg::*;
#(
  parameter int unsigned NIBBLES = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   loop_perm_to_count,
  input  AluCtrl                 ctrl,
  input  logic [2:0]             loop_nibbles_number,
  input  logic                   word2_is_negative,
  input  logic [4*NIBBLES-1:0]   word1,
  input  logic [4*NIBBLES-1:0]   word2,
  input  logic [4*NIBBLES-1:0]   preinit_result,
  output logic [4*NIBBLES-1:0]   result,
  output logic                   busy
);

  localparam logic [2:0] LastIdx = 3'(NIBBLES - 1);

  AluState              state_q, state_d;
  logic [2:0]           curr_nibble_idx_q, curr_nibble_idx_d;
  logic                 result_carry_q, result_carry_d;
  logic [4*NIBBLES-1:0] result_q, result_d;

  logic [2:0]           cur_idx;
  logic [4*NIBBLES-1:0] base_result, step_result;
  logic                 base_carry;
  logic [3:0]           nib_a, nib_b, nib_s;
  logic                 nib_cout;
  logic                 finish;

  logic unused_ctrl;
  assign unused_ctrl = ^ctrl.reserved;

  nibble_adder u_nibble_adder (
    .a_i    (nib_a),
    .b_i    (nib_b),
    .cin_i  (base_carry),
    .s_o    (nib_s),
    .cout_o (nib_cout)
  );

  // In IDLE the step works on the freshly preloaded values, so nibble 0 completes on the
  // same edge that accepts the request.
  always_comb begin
    cur_idx     = (state_q == AluIdle) ? 3'd0 : curr_nibble_idx_q;
    base_result = (state_q == AluIdle) ? preinit_result : result_q;
    base_carry  = (state_q == AluIdle) ? ctrl.carry_in : result_carry_q;
    nib_a       = word1[{cur_idx, 2'b00} +: 4];
    nib_b       = (cur_idx <= loop_nibbles_number) ? word2[{cur_idx, 2'b00} +: 4]
                                                   : {4{word2_is_negative}};
    finish      = (cur_idx == LastIdx) ||
                  ((cur_idx >= loop_nibbles_number) && !nib_cout && !word2_is_negative);
    step_result = base_result;
    step_result[{cur_idx, 2'b00} +: 4] = nib_s;
    // Nothing left to add above an early finish, so the upper nibbles are just word1.
    if (finish) begin
      for (int j = 0; j < int'(NIBBLES); j++) begin
        if (j > int'(cur_idx)) step_result[4*j +: 4] = word1[4*j +: 4];
      end
    end
  end

  always_comb begin
    state_d           = state_q;
    curr_nibble_idx_d = curr_nibble_idx_q;
    result_carry_d    = result_carry_q;
    result_d          = result_q;
    unique case (state_q)
      AluIdle: begin
        result_d          = preinit_result;
        curr_nibble_idx_d = 3'd0;
        result_carry_d    = ctrl.carry_in;
        if (loop_perm_to_count) begin
          result_d          = step_result;
          result_carry_d    = nib_cout;
          curr_nibble_idx_d = cur_idx + 3'd1;
          state_d           = finish ? AluDone : AluRun;
        end
      end
      AluRun: begin
        if (!loop_perm_to_count) begin
          state_d = AluIdle;
        end else begin
          result_d          = step_result;
          result_carry_d    = nib_cout;
          curr_nibble_idx_d = cur_idx + 3'd1;
          if (finish) state_d = AluDone;
        end
      end
      AluDone: begin
        if (!loop_perm_to_count) state_d = AluIdle;
      end
      default: state_d = AluIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= AluIdle;
      curr_nibble_idx_q <= 3'd0;
      result_carry_q    <= 1'b0;
      result_q          <= '0;
    end else begin
      state_q           <= state_d;
      curr_nibble_idx_q <= curr_nibble_idx_d;
      result_carry_q    <= result_carry_d;
      result_q          <= result_d;
    end
  end

  assign result = result_q;
  // Gated by rst_n so busy drops the moment reset is asserted, even with the request held.
  assign busy   = rst_n && loop_perm_to_count && (state_q != AluDone);

endmodule

// File: tb/tb_loop_over_all_nibbles.sv
module tb_loop_over_all_nibbles;
  import cpu_pkg::*;

  typedef struct {
    logic [31:0] w1;
    logic [31:0] w2;
    logic [2:0]  loop_n;
    logic        neg;
    logic        cin;
    logic [31:0] preinit;
    logic [31:0] exp_result;
    int          exp_cycles;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  AluCtrl      ctrl = '0;
  logic [2:0]  loop_n = '0;
  logic        neg = 1'b0;
  logic [31:0] word1 = '0, word2 = '0, preinit = '0;
  logic [31:0] result;
  logic        busy;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  loop_over_all_nibbles #(.NIBBLES(8)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .loop_perm_to_count  (req),
    .ctrl                (ctrl),
    .loop_nibbles_number (loop_n),
    .word2_is_negative   (neg),
    .word1               (word1),
    .word2               (word2),
    .preinit_result      (preinit),
    .result              (result),
    .busy                (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: whole-word arithmetic on the extended addend.
  function automatic logic [31:0] ext_word2(input logic [31:0] w2, input logic [2:0] l,
                                            input logic n);
    logic [31:0] mask;
    mask = (l == 3'd7) ? 32'hFFFF_FFFF : ((32'd1 << (4 * (int'(l) + 1))) - 32'd1);
    return n ? ((w2 & mask) | ~mask) : (w2 & mask);
  endfunction

  function automatic vec_t model(input logic [31:0] w1, input logic [31:0] w2,
                                 input logic [2:0] l, input logic n, input logic c,
                                 input logic [31:0] pre);
    vec_t v;
    logic [31:0] e;
    logic [32:0] part;
    logic [32:0] m;
    v.w1 = w1; v.w2 = w2; v.loop_n = l; v.neg = n; v.cin = c; v.preinit = pre;
    e = ext_word2(w2, l, n);
    v.exp_result = w1 + e + {31'd0, c};
    v.exp_cycles = 8;
    for (int i = 0; i < 8; i++) begin
      m = (33'd1 << (4 * (i + 1))) - 33'd1;
      part = ({1'b0, w1} & m) + ({1'b0, e} & m) + {32'd0, c};
      if (i >= int'(l) && part[4 * (i + 1)] == 1'b0 && !n) begin
        v.exp_cycles = i + 1;
        break;
      end
    end
    return v;
  endfunction

  task automatic apply(input vec_t v);
    ctrl.carry_in = v.cin; ctrl.reserved = 3'd0;
    loop_n = v.loop_n; neg = v.neg;
    word1 = v.w1; word2 = v.w2; preinit = v.preinit;
  endtask

  // Runs one op from IDLE; returns with the request still high, state DONE.
  task automatic run_op(input vec_t v, input string tag);
    int cycles;
    @(posedge clk); #1;
    apply(v);
    req = 1'b1;
    #1;
    check({tag, " busy_rise"}, {31'd0, busy}, 32'd1);
    cycles = 0;
    while (busy && cycles < 20) begin
      @(posedge clk); #1;
      cycles++;
    end
    check({tag, " cycles"}, cycles, v.exp_cycles);
    check({tag, " result"}, result, v.exp_result);
  endtask

  task automatic release_req(input vec_t v, input string tag);
    req = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check({tag, " preinit"}, result, v.preinit);
  endtask

  vec_t tbl[6];
  vec_t v;

  initial begin
    tbl[0] = '{32'hFF, 32'd4, 3'd0, 1'b0, 1'b0, 32'h1111_1111, 32'h103, 3};
    tbl[1] = '{32'h0, 32'd123, 3'd2, 1'b0, 1'b0, 32'h0, 32'd123, 3};
    tbl[2] = '{32'h0, 32'h800, 3'd2, 1'b1, 1'b0, 32'hA5A5_A5A5, 32'hFFFF_F800, 8};
    tbl[3] = '{32'h7B, 32'hFFE, 3'd2, 1'b1, 1'b0, 32'h0, 32'h79, 8};
    tbl[4] = '{32'hFFFF_FFFF, 32'h0, 3'd7, 1'b0, 1'b1, 32'h5, 32'h0, 8};
    tbl[5] = '{32'h1, 32'h2, 3'd7, 1'b0, 1'b0, 32'h7, 32'h3, 8};

    #3;
    check("reset result", result, 32'h0);
    check("reset busy", {31'd0, busy}, 32'd0);
    #20 rst_n = 1'b1;

    for (int k = 0; k < 6; k++) begin
      run_op(tbl[k], $sformatf("vec%0d", k));
      release_req(tbl[k], $sformatf("vec%0d", k));
    end

    // Request held after completion: no restart, result stays put.
    run_op(tbl[0], "hold");
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check("hold busy", {31'd0, busy}, 32'd0);
      check("hold result", result, 32'h103);
    end
    release_req(tbl[0], "hold");

    // Abort mid-run returns to IDLE, which reloads preinit.
    v = model(32'h1234_5678, 32'h0, 3'd7, 1'b0, 1'b0, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    apply(v);
    req = 1'b1;
    repeat (3) @(posedge clk);
    #1 req = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort preinit", result, 32'hDEAD_BEEF);

    // Randomised ops against the model.
    for (int k = 0; k < 40; k++) begin
      v = model($urandom, $urandom & ((k % 2 == 0) ? 32'hFFF : 32'hFFFF_FFFF),
                3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), $urandom);
      run_op(v, $sformatf("rnd%0d", k));
      release_req(v, $sformatf("rnd%0d", k));
    end

    // Asynchronous reset in the middle of a run.
    v = model(32'h0, 32'h800, 3'd2, 1'b1, 1'b0, 32'h1);
    @(posedge clk); #1;
    apply(v);
    req = 1'b1;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async rst result", result, 32'h0);
    check("async rst busy", {31'd0, busy}, 32'd0);
    req = 1'b0;
    #7 rst_n = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("post rst preinit", result, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
